pc_control_unit: RTL and testbench

PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

---
 rtl/pc_control_unit.sv | 97 +++++++++
 tb/tb_pc_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_control_unit.sv
// Program counter sequencer: owns the fetch address, applies branch/jump redirects
// with a one-cycle bubble, and counts completed instruction fetches.
module pc_control_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Stall,
  input  logic        FetchReady,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult,
  output logic        FetchValid,
  output logic        Flush,
  output logic [31:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL,
    REDIRECT
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] count_r;
  logic        fetch_valid_r;
  logic        flush_r;

  logic        redirect;
  logic        xfer;
  logic [31:0] target;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign redirect    = (state != IDLE) && (PCSrc || Jump);
  assign xfer        = fetch_valid_r && FetchReady && !Stall;
  assign target      = word_align(PCSrc ? BranchTarget : JumpTarget);
  assign PCAddResult = pc_r + 32'd4;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= IDLE;
      pc_r          <= word_align(RESET_VECTOR);
      count_r       <= '0;
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
    end else begin
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
      // A transfer is counted even when a redirect wins the PC update
      if (xfer) count_r <= count_r + 32'd1;
      if (redirect) begin
        pc_r    <= target;
        state   <= REDIRECT;
        flush_r <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state         <= FETCH;
            fetch_valid_r <= 1'b1;
          end
          FETCH: begin
            if (Stall) begin
              state <= STALL;
            end else begin
              if (FetchReady) pc_r <= PCAddResult;
              fetch_valid_r <= 1'b1;
            end
          end
          STALL: begin
            if (!Stall) begin
              state         <= FETCH;
              fetch_valid_r <= 1'b1;
            end
          end
          default: begin
            state         <= FETCH;
            fetch_valid_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign PCResult   = pc_r;
  assign InstrCount = count_r;
  assign FetchValid = fetch_valid_r;
  assign Flush      = flush_r;

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: directed scenarios then random traffic,
// each edge's expected outputs queued by a behavioural model and checked by a monitor.
module tb_pc_control_unit;

  logic        Clk;
  logic        Reset;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Stall;
  logic        FetchReady;
  logic [31:0] PCResult;
  logic [31:0] PCAddResult;
  logic        FetchValid;
  logic        Flush;
  logic [31:0] InstrCount;

  pc_control_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Stall(Stall), .FetchReady(FetchReady),
    .PCResult(PCResult), .PCAddResult(PCAddResult), .FetchValid(FetchValid),
    .Flush(Flush), .InstrCount(InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        fv;
    logic        flush;
  } exp_t;

  typedef enum {M_IDLE, M_FETCH, M_HOLD, M_BUBBLE} mode_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  mode_t       m_mode = M_IDLE;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_cnt  = 32'h0;

  // Reference: what the block's visible state becomes after the coming edge
  task automatic step(input logic rst_n, input logic bsrc, input logic [31:0] bt,
                      input logic jmp, input logic [31:0] jt,
                      input logic stl, input logic rdy);
    exp_t e;
    logic fetching;
    @(negedge Clk);
    Reset = rst_n; PCSrc = bsrc; BranchTarget = bt; Jump = jmp;
    JumpTarget = jt; Stall = stl; FetchReady = rdy;
    e.flush = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 32'h0; m_cnt = 32'h0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_FETCH;
    end else begin
      fetching = (m_mode == M_FETCH);
      if (fetching && rdy && !stl) m_cnt = m_cnt + 1;
      if (bsrc || jmp) begin
        m_pc    = (bsrc ? bt : jt) & 32'hFFFF_FFFC;
        m_mode  = M_BUBBLE;
        e.flush = 1'b1;
      end else if (m_mode == M_FETCH) begin
        if (stl) m_mode = M_HOLD;
        else if (rdy) m_pc = m_pc + 4;
      end else if (m_mode == M_HOLD) begin
        if (!stl) m_mode = M_FETCH;
      end else begin
        m_mode = M_FETCH;
      end
    end
    e.pc  = m_pc;
    e.cnt = m_cnt;
    e.fv  = (m_mode == M_FETCH);
    sb.push_back(e);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check32("PCResult",    PCResult,    e.pc);
        check32("PCAddResult", PCAddResult, e.pc + 32'd4);
        check32("InstrCount",  InstrCount,  e.cnt);
        check32("FetchValid",  {31'b0, FetchValid}, {31'b0, e.fv});
        check32("Flush",       {31'b0, Flush},      {31'b0, e.flush});
        check32("PCAlign",     {30'b0, PCResult[1:0]}, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; PCSrc = 1'b0; BranchTarget = '0; Jump = 1'b0;
    JumpTarget = '0; Stall = 1'b0; FetchReady = 1'b0;

    // Reset then straight-line fetch
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1);

    // Branch from 0x10 to 0x40
    step(1, 0, 0, 1, 32'h10, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);

    // Branch beats jump; stall does not block redirect; transfer+redirect same edge
    step(1, 1, 32'h80, 1, 32'h200, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'h123, 0, 0, 1, 1);
    step(1, 0, 0, 1, 32'h301, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 32'h20, 0, 1);

    // Stall at 0x20
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);

    // Address wrap and held fetch
    step(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Reset while in the redirect bubble with a branch pending
    step(1, 1, 32'h100, 0, 0, 0, 1);
    step(0, 1, 32'h100, 1, 32'h300, 0, 1);
    step(1, 1, 32'h500, 1, 32'h600, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0));
    end

    @(negedge Clk);
    @(negedge Clk);
    check32("ScoreboardDrained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
